// File: rtl/gemm_tile_scheduler.sv
// rtl/gemm_tile_scheduler.sv - sequences one tiled GEMM job: DMA tile loads, PE chunk runs, status
// Walks output tiles (nt inner, mt outer) and K-chunks per tile from latched job registers.
module gemm_tile_scheduler #(
  parameter int TILE       = 16,
  parameter int ELEM_BYTES = 1,
  parameter int MAX_DIM    = 1024,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [31:0]      m_size_i,
  input  logic [31:0]      k_size_i,
  input  logic [31:0]      n_size_i,
  input  logic [31:0]      wgt_base_i,
  input  logic [31:0]      inp_base_i,
  output logic [31:0]      status_o,
  output logic             dma_req_valid_o,
  input  logic             dma_req_ready_i,
  output logic             dma_req_sel_o,
  output logic [31:0]      dma_req_addr_o,
  output logic [15:0]      dma_req_len_o,
  input  logic             dma_done_i,
  output logic             pe_start_o,
  output logic             pe_acc_clear_o,
  input  logic             pe_done_i,
  output logic             tile_done_o,
  output logic [CNT_W-1:0] out_tile_m_o,
  output logic [CNT_W-1:0] out_tile_n_o
);

  localparam int TILE_BYTES = TILE * TILE * ELEM_BYTES;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CHECK   = 4'd1,
    REQ_W   = 4'd2,
    WAIT_W  = 4'd3,
    REQ_I   = 4'd4,
    WAIT_I  = 4'd5,
    RUN     = 4'd6,
    WAIT_PE = 4'd7,
    NEXT    = 4'd8,
    DONE    = 4'd9
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       m_q, m_d, k_q, k_d, n_q, n_d;
  logic [31:0]       wbase_q, wbase_d, ibase_q, ibase_d;
  logic [CNT_W-1:0]  mt_q, mt_d, nt_q, nt_d, kt_q, kt_d;
  logic [CNT_W-1:0]  mtn_q, mtn_d, ntn_q, ntn_d, ktn_q, ktn_d;
  logic              hold_q, hold_d;
  logic              abort_seen_q, abort_seen_d;
  logic              done_q, done_d, cfg_err_q, cfg_err_d, aborted_q, aborted_d;
  logic [15:0]       tiles_done_q, tiles_done_d;
  logic              tile_done_q, tile_done_d;
  logic [CNT_W-1:0]  out_m_q, out_m_d, out_n_q, out_n_d;

  logic              abort_act;
  logic [31:0]       w_addr, i_addr;

  function automatic logic size_bad(input logic [31:0] sz);
    return (sz == 32'd0) || (sz > 32'(MAX_DIM));
  endfunction

  function automatic logic [CNT_W-1:0] tiles_of(input logic [31:0] sz);
    return CNT_W'((sz + 32'(TILE - 1)) / 32'(TILE));
  endfunction

  // A level abort seen mid-wait is remembered so it is honoured at the next safe point.
  assign abort_act = abort_i | abort_seen_q;
  assign w_addr = wbase_q + (32'(kt_q) * 32'(ntn_q) + 32'(nt_q)) * 32'(TILE_BYTES);
  assign i_addr = ibase_q + (32'(mt_q) * 32'(ktn_q) + 32'(kt_q)) * 32'(TILE_BYTES);

  assign status_o     = {tiles_done_q, 8'h00, 4'(state_q), aborted_q, cfg_err_q, done_q,
                         (state_q != IDLE)};
  assign tile_done_o  = tile_done_q;
  assign out_tile_m_o = out_m_q;
  assign out_tile_n_o = out_n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      m_q          <= '0;
      k_q          <= '0;
      n_q          <= '0;
      wbase_q      <= '0;
      ibase_q      <= '0;
      mt_q         <= '0;
      nt_q         <= '0;
      kt_q         <= '0;
      mtn_q        <= '0;
      ntn_q        <= '0;
      ktn_q        <= '0;
      hold_q       <= 1'b0;
      abort_seen_q <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      aborted_q    <= 1'b0;
      tiles_done_q <= '0;
      tile_done_q  <= 1'b0;
      out_m_q      <= '0;
      out_n_q      <= '0;
    end else begin
      state_q      <= state_d;
      m_q          <= m_d;
      k_q          <= k_d;
      n_q          <= n_d;
      wbase_q      <= wbase_d;
      ibase_q      <= ibase_d;
      mt_q         <= mt_d;
      nt_q         <= nt_d;
      kt_q         <= kt_d;
      mtn_q        <= mtn_d;
      ntn_q        <= ntn_d;
      ktn_q        <= ktn_d;
      hold_q       <= hold_d;
      abort_seen_q <= abort_seen_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
      aborted_q    <= aborted_d;
      tiles_done_q <= tiles_done_d;
      tile_done_q  <= tile_done_d;
      out_m_q      <= out_m_d;
      out_n_q      <= out_n_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    m_d             = m_q;
    k_d             = k_q;
    n_d             = n_q;
    wbase_d         = wbase_q;
    ibase_d         = ibase_q;
    mt_d            = mt_q;
    nt_d            = nt_q;
    kt_d            = kt_q;
    mtn_d           = mtn_q;
    ntn_d           = ntn_q;
    ktn_d           = ktn_q;
    hold_d          = hold_q;
    abort_seen_d    = abort_seen_q;
    done_d          = done_q;
    cfg_err_d       = cfg_err_q;
    aborted_d       = aborted_q;
    tiles_done_d    = tiles_done_q;
    tile_done_d     = 1'b0;
    out_m_d         = out_m_q;
    out_n_d         = out_n_q;
    dma_req_valid_o = 1'b0;
    dma_req_sel_o   = 1'b0;
    dma_req_addr_o  = '0;
    dma_req_len_o   = '0;
    pe_start_o      = 1'b0;
    pe_acc_clear_o  = 1'b0;

    if (state_q != IDLE && abort_i) abort_seen_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d      = CHECK;
          m_d          = m_size_i;
          k_d          = k_size_i;
          n_d          = n_size_i;
          wbase_d      = wgt_base_i;
          ibase_d      = inp_base_i;
          done_d       = 1'b0;
          cfg_err_d    = 1'b0;
          aborted_d    = 1'b0;
          tiles_done_d = '0;
          abort_seen_d = 1'b0;
          hold_d       = 1'b0;
        end
      end
      CHECK: begin
        if (size_bad(m_q) || size_bad(k_q) || size_bad(n_q)) begin
          cfg_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          mtn_d   = tiles_of(m_q);
          ktn_d   = tiles_of(k_q);
          ntn_d   = tiles_of(n_q);
          mt_d    = '0;
          nt_d    = '0;
          kt_d    = '0;
          state_d = REQ_W;
        end
      end
      REQ_W, REQ_I: begin
        // Once valid has been shown it stays up until accepted, abort or not.
        if (!hold_q && abort_act) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else begin
          dma_req_valid_o = 1'b1;
          dma_req_sel_o   = (state_q == REQ_I);
          dma_req_addr_o  = (state_q == REQ_I) ? i_addr : w_addr;
          dma_req_len_o   = 16'(TILE_BYTES);
          if (dma_req_ready_i) begin
            hold_d  = 1'b0;
            state_d = (state_q == REQ_I) ? WAIT_I : WAIT_W;
          end else begin
            hold_d = 1'b1;
          end
        end
      end
      WAIT_W:  if (dma_done_i) state_d = REQ_I;
      WAIT_I:  if (dma_done_i) state_d = RUN;
      RUN: begin
        pe_start_o     = 1'b1;
        pe_acc_clear_o = (kt_q == '0);
        state_d        = WAIT_PE;
      end
      WAIT_PE: if (pe_done_i) state_d = NEXT;
      NEXT: begin
        if (abort_act) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (kt_q < ktn_q - ONE) begin
          kt_d    = kt_q + ONE;
          state_d = REQ_W;
        end else begin
          tile_done_d = 1'b1;
          out_m_d     = mt_q;
          out_n_d     = nt_q;
          kt_d        = '0;
          if (tiles_done_q != 16'hFFFF) tiles_done_d = tiles_done_q + 16'd1;
          if (mt_q == mtn_q - ONE && nt_q == ntn_q - ONE) begin
            state_d = DONE;
          end else begin
            state_d = REQ_W;
            if (nt_q == ntn_q - ONE) begin
              nt_d = '0;
              mt_d = mt_q + ONE;
            end else begin
              nt_d = nt_q + ONE;
            end
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
